// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one wait-state memory bus between the fetch port and
// the load/store port. Load/store normally has priority because it belongs to
// the older instruction. A watchdog aborts a grant that never sees bus_ack_i.
// Optional build macro ARB_FAIR_EN: alternate the winner under contention
// (round robin) instead of fixed load/store-first priority.
//
// state  | meaning
// IDLE   | bus free; arbitrate between eligible requests
// I_BUSY | fetch access on the bus, waiting for bus_ack_i or watchdog expiry
// D_BUSY | load/store access on the bus, waiting for bus_ack_i or watchdog expiry
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_sel_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  // Watchdog fires at the edge that would make the busy-cycle count reach TIMEOUT_CYC.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wd_cnt;
  logic            i_elig, d_elig, d_first;
  logic            grant_i, grant_d, busy, to_hit;

`ifdef ARB_FAIR_EN
  logic last_d;  // 1 = load/store port was granted last, 0 = fetch port

  // Remember the last winner so contention alternates between the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (grant_d) begin
      last_d <= 1'b1;
    end else if (grant_i) begin
      last_d <= 1'b0;
    end
  end

  assign d_first = ~last_d;
`else
  assign d_first = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on ack or watchdog expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nxt = D_BUSY;
        end else if (grant_i) begin
          state_nxt = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus_ack_i || to_hit) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode: eligibility, grant decisions, watchdog expiry and pipeline stall.
  always_comb begin
    // A port whose ack is pulsing this cycle is not eligible, so the completing
    // request cannot be granted a second time.
    i_elig     = i_req_i & ~i_ack_o;
    d_elig     = d_req_i & ~d_ack_o;
    grant_d    = (state == IDLE) & d_elig & (d_first | ~i_elig);
    grant_i    = (state == IDLE) & i_elig & ~grant_d;
    busy       = (state == I_BUSY) | (state == D_BUSY);
    to_hit     = (TIMEOUT_CYC != 0) && (wd_cnt == TO_LAST);
    stallreq_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);
  end

  // Bus request registers, completion pulses, read data capture and watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= 4'h0;
      bus_addr_o  <= 32'h0;
      bus_wdata_o <= 32'h0;
      i_rdata_o   <= 32'h0;
      d_rdata_o   <= 32'h0;
      i_ack_o     <= 1'b0;
      d_ack_o     <= 1'b0;
      bus_err_o   <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      i_ack_o   <= 1'b0;
      d_ack_o   <= 1'b0;
      bus_err_o <= 1'b0;
      if (grant_i || grant_d) begin
        bus_req_o   <= 1'b1;
        bus_we_o    <= grant_d & d_we_i;
        bus_sel_o   <= grant_d ? d_sel_i : 4'hF;
        bus_addr_o  <= grant_d ? d_addr_i : i_addr_i;
        bus_wdata_o <= grant_d ? d_wdata_i : 32'h0;
        wd_cnt      <= '0;
      end else if (busy) begin
        if (bus_ack_i) begin
          // An ack on the expiry edge wins over the watchdog.
          bus_req_o <= 1'b0;
          if (state == D_BUSY) begin
            d_rdata_o <= bus_rdata_i;
            d_ack_o   <= 1'b1;
          end else begin
            i_rdata_o <= bus_rdata_i;
            i_ack_o   <= 1'b1;
          end
        end else if (to_hit) begin
          bus_req_o <= 1'b0;
          bus_err_o <= 1'b1;
          if (state == D_BUSY) begin
            d_rdata_o <= 32'h0;
            d_ack_o   <= 1'b1;
          end else begin
            i_rdata_o <= 32'h0;
            i_ack_o   <= 1'b1;
          end
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized fetch/load-store traffic against a random-latency
// memory responder; a transaction-level scoreboard predicts grant order, bus fields,
// completion data and watchdog aborts.
module tb_mem_bus_arbiter;
  localparam int TO  = 8;
  localparam int NTX = 150;

  logic        clk, rst;
  logic        i_req, d_req, d_we, bus_ack;
  logic [31:0] i_addr, d_addr, d_wdata, bus_rdata;
  logic [3:0]  d_sel;
  logic [31:0] i_rdata_o, d_rdata_o, bus_addr_o, bus_wdata_o;
  logic        i_ack_o, d_ack_o, bus_req_o, bus_we_o, bus_err_o, stallreq_o;
  logic [3:0]  bus_sel_o;

  mem_bus_arbiter #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .d_req_i(d_req), .d_we_i(d_we), .d_sel_i(d_sel), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata),
    .bus_ack_i(bus_ack), .bus_err_o(bus_err_o), .stallreq_o(stallreq_o)
  );

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        m;      // 1 = load/store port, 0 = fetch port
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  req_t q_i[$];
  req_t q_d[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic cur_m = 1'b0;
  bit   i_done = 0;
  bit   d_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; bus_ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; bus_rdata = 0; d_sel = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", bus_req_o, 0);
    chk("rst_bus_we", bus_we_o, 0);
    chk("rst_bus_sel", bus_sel_o, 0);
    chk("rst_bus_addr", bus_addr_o, 0);
    chk("rst_bus_wdata", bus_wdata_o, 0);
    chk("rst_i_rdata", i_rdata_o, 0);
    chk("rst_d_rdata", d_rdata_o, 0);
    chk("rst_i_ack", i_ack_o, 0);
    chk("rst_d_ack", d_ack_o, 0);
    chk("rst_bus_err", bus_err_o, 0);
    chk("rst_stallreq", stallreq_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset two cycles into a load grant discards the access; a later stray ack is ignored.
    @(negedge clk);
    d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h300;
    @(posedge clk); #1;
    chk("rg_granted", bus_req_o, 1);
    chk("rg_addr", bus_addr_o, 32'h300);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rg_req_after_rst", bus_req_o, 0);
    chk("rg_ack_after_rst", d_ack_o, 0);
    chk("rg_err_after_rst", bus_err_o, 0);
    @(negedge clk);
    rst = 1'b0; d_req = 0; bus_ack = 1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("rg_stray_ack", d_ack_o, 0);
    chk("rg_stray_req", bus_req_o, 0);
    @(negedge clk);
    bus_ack = 0;
    @(posedge clk); #1;
    chk("rg_no_late_ack", d_ack_o, 0);
    chk("rg_d_rdata", d_rdata_o, 0);

    fork
      // Fetch master
      begin
        for (int n = 0; n < NTX; n++) begin
          req_t r;
          int   w;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          r.we = 1'b0; r.sel = 4'hF; r.addr = $urandom() & 32'hFFFF_FFFC; r.wdata = 32'h0;
          i_addr = r.addr;
          q_i.push_back(r);
          i_req = 1'b1;
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (!i_ack_o && w < 40);
          chk("i_ack_wait", i_ack_o, 1);
          i_req = 1'b0;
        end
        i_done = 1;
      end
      // Load/store master
      begin
        for (int n = 0; n < NTX; n++) begin
          req_t r;
          int   w;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          r.we = 1'($urandom_range(0, 1));
          r.sel = 4'($urandom_range(1, 15));
          r.addr = $urandom() & 32'hFFFF_FFFC;
          r.wdata = $urandom();
          d_we = r.we; d_sel = r.sel; d_addr = r.addr; d_wdata = r.wdata;
          q_d.push_back(r);
          d_req = 1'b1;
          w = 0;
          do begin
            @(negedge clk);
            w++;
          end while (!d_ack_o && w < 40);
          chk("d_ack_wait", d_ack_o, 1);
          d_req = 1'b0;
        end
        d_done = 1;
      end
      // Memory responder: random latency, occasional no-ack (watchdog) and stray acks
      begin
        int   cnt = 0;
        int   dly = 0;
        rsp_t e;
        forever begin
          @(negedge clk);
          bus_ack = 1'b0;
          if (bus_req_o) begin
            if (cnt == 0) begin
              dly = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 12) : $urandom_range(1, 5);
            end
            cnt++;
            if (cnt == dly) begin
              bus_rdata = $urandom();
              bus_ack = 1'b1;
              e.m = cur_m; e.rdata = bus_rdata; e.err = 1'b0;
              rsp_q.push_back(e);
            end else if (cnt == TO && dly > TO) begin
              e.m = cur_m; e.rdata = 32'h0; e.err = 1'b1;
              rsp_q.push_back(e);
            end
          end else begin
            cnt = 0;
            if ($urandom_range(0, 15) == 0) begin
              bus_ack = 1'b1;
              bus_rdata = $urandom();
            end
          end
        end
      end
      // Monitor / scoreboard
      begin
        logic p_breq = 0, p_iack = 0, p_dack = 0;
        logic i_el, d_el;
        logic last_m = 1'b0;
        logic [31:0] i_exp = 32'h0;
        req_t g = '0;
        req_t x;
        rsp_t r;
        forever begin
          @(posedge clk); #1;
          i_el = i_req & ~p_iack;
          d_el = d_req & ~p_dack;
          chk("stallreq", stallreq_o, (i_req & ~i_ack_o) | (d_req & ~d_ack_o));
          if (!p_breq) begin
            chk("grant_when_eligible", bus_req_o, i_el | d_el);
            if (bus_req_o && (i_el | d_el)) begin
`ifdef ARB_FAIR_EN
              cur_m = (i_el && d_el) ? ~last_m : d_el;
`else
              cur_m = d_el;
`endif
              last_m = cur_m;
              if ((cur_m ? q_d.size() : q_i.size()) == 0) begin
                chk("grant_has_request", 0, 1);
              end else begin
                x = cur_m ? q_d[0] : q_i[0];
                chk("grant_we", bus_we_o, x.we);
                chk("grant_sel", bus_sel_o, x.sel);
                chk("grant_addr", bus_addr_o, x.addr);
                if (x.we) chk("grant_wdata", bus_wdata_o, x.wdata);
              end
              g.we = bus_we_o; g.sel = bus_sel_o; g.addr = bus_addr_o; g.wdata = bus_wdata_o;
            end
          end else if (bus_req_o) begin
            chk("bus_addr_stable", bus_addr_o, g.addr);
            chk("bus_ctl_stable", {bus_we_o, bus_sel_o, bus_wdata_o[26:0]},
                {g.we, g.sel, g.wdata[26:0]});
          end
          if (i_ack_o || d_ack_o) begin
            chk("ack_exclusive", i_ack_o & d_ack_o, 0);
            chk("bus_req_low_on_ack", bus_req_o, 0);
            if (rsp_q.size() == 0) begin
              chk("ack_expected", 0, 1);
            end else begin
              r = rsp_q.pop_front();
              chk("ack_port", d_ack_o, r.m);
              chk("ack_bus_err", bus_err_o, r.err);
              if (r.m) begin
                if (r.err || !g.we) chk("d_rdata", d_rdata_o, r.rdata);
                if (q_d.size() != 0) void'(q_d.pop_front());
              end else begin
                chk("i_rdata", i_rdata_o, r.rdata);
                i_exp = r.rdata;
                if (q_i.size() != 0) void'(q_i.pop_front());
              end
            end
          end else begin
            chk("bus_err_without_ack", bus_err_o, 0);
            chk("i_rdata_hold", i_rdata_o, i_exp);
          end
          p_breq = bus_req_o;
          p_iack = i_ack_o;
          p_dack = d_ack_o;
        end
      end
    join_none

    for (int c = 0; c < 20000 && !(i_done && d_done); c++) @(posedge clk);
    chk("masters_finished", {31'h0, i_done && d_done}, 1);
    repeat (20) @(posedge clk);
    #2;
    chk("rsp_queue_drained", rsp_q.size(), 0);
    chk("i_queue_drained", q_i.size(), 0);
    chk("d_queue_drained", q_d.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
